// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and types for the 8-digit 7-segment scan controller.
//   DIGITS, ANODE_OFF, SEG_OFF, SEG_TABLE (active-low, seg[0]=a .. seg[6]=g),
//   slot_state_e {BLANK, SHOW}.
package disp_pkg;

  localparam int unsigned DIGITS = 8;

  localparam logic [7:0] ANODE_OFF = 8'hFF;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  // Glyphs 0-9, A, b, C, d, E, F; bit order {g,f,e,d,c,b,a}, 0 = segment lit.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/hex7seg_decode.sv
// hex7seg_decode: combinational hex nibble to active-low 7-segment pattern.
//   nibble in  [3:0]  hex digit
//   seg    out [6:0]  active-low cathodes, seg[0]=a .. seg[6]=g
module hex7seg_decode
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: scans an 8-digit active-low 7-segment display.
//   clk, rst          clock, asynchronous active-high reset
//   load_valid/ready  handshake for a new display word (double-buffered,
//                     applied at frame boundaries only)
//   load_data/mask/dp 32-bit hex word, per-digit enable, per-digit point
//   anode, seg, dp    registered active-low display drive
//   frame_done        one-cycle pulse after the digit-7 slot ends
// Optional: define DISP_LZB_EN for leading-zero blanking.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_mask,
  input  logic [7:0]  load_dp,
  output logic [7:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  slot_state_e      state_q, state_d;

  logic [31:0] act_data_q, act_data_d;
  logic [7:0]  act_mask_q, act_mask_d;
  logic [7:0]  act_dp_q, act_dp_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic [7:0]  pend_mask_q, pend_mask_d;
  logic [7:0]  pend_dp_q, pend_dp_d;
  logic        pend_full_q, pend_full_d;

  logic [7:0]  anode_q, anode_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_done_q, frame_done_d;

  logic        cnt_end;
  logic        boundary;
  logic [7:0]  vis_mask;
  logic [3:0]  nibble;
  logic [6:0]  seg_dec;
  logic        lit;

  assign load_ready = !pend_full_q;

  // Visible digits: mask, optionally trimmed above the most significant
  // nonzero nibble. Scanning from the top keeps a running "something
  // nonzero at or above this digit" flag.
`ifdef DISP_LZB_EN
  logic upper_nz;
  always_comb begin
    upper_nz    = 1'b0;
    vis_mask    = '0;
    vis_mask[0] = act_mask_q[0];
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      upper_nz    = upper_nz | (|act_data_q[4*i +: 4]);
      vis_mask[i] = act_mask_q[i] & upper_nz;
    end
  end
`else
  always_comb begin
    vis_mask = act_mask_q;
  end
`endif

  always_comb begin
    nibble = act_data_q[4*idx_q +: 4];
  end

  hex7seg_decode u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  always_comb begin
    cnt_end  = (cnt_q == CNT_LAST);
    boundary = cnt_end && (idx_q == 3'd7);

    cnt_d = cnt_end ? '0 : cnt_q + 1'b1;
    idx_d = cnt_end ? idx_q + 3'd1 : idx_q;

    state_d = state_q;
    case (state_q)
      BLANK: if (cnt_q == BLANK_LAST) state_d = SHOW;
      SHOW:  if (cnt_end)             state_d = BLANK;
      default: state_d = BLANK;
    endcase

    act_data_d  = act_data_q;
    act_mask_d  = act_mask_q;
    act_dp_d    = act_dp_q;
    pend_data_d = pend_data_q;
    pend_mask_d = pend_mask_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;

    // Promotion and acceptance are exclusive: acceptance needs an empty
    // pending buffer, promotion needs a full one.
    if (boundary && pend_full_q) begin
      act_data_d  = pend_data_q;
      act_mask_d  = pend_mask_q;
      act_dp_d    = pend_dp_q;
      pend_full_d = 1'b0;
    end else if (load_valid && !pend_full_q) begin
      pend_data_d = load_data;
      pend_mask_d = load_mask;
      pend_dp_d   = load_dp;
      pend_full_d = 1'b1;
    end

    lit          = (state_q == SHOW) && vis_mask[idx_q];
    anode_d      = lit ? ~(8'h01 << idx_q) : ANODE_OFF;
    seg_d        = lit ? seg_dec : SEG_OFF;
    dp_d         = lit ? ~act_dp_q[idx_q] : 1'b1;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= BLANK;
      act_data_q   <= '0;
      act_mask_q   <= '0;
      act_dp_q     <= '0;
      pend_data_q  <= '0;
      pend_mask_q  <= '0;
      pend_dp_q    <= '0;
      pend_full_q  <= 1'b0;
      anode_q      <= ANODE_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      act_data_q   <= act_data_d;
      act_mask_q   <= act_mask_d;
      act_dp_q     <= act_dp_d;
      pend_data_q  <= pend_data_d;
      pend_mask_q  <= pend_mask_d;
      pend_dp_q    <= pend_dp_d;
      pend_full_q  <= pend_full_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anode      = anode_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Controller that sequences the 8-digit, active-low 7-segment display.
- Generates the digit-slot timing and rotates a one-hot active-low anode.
- Per digit, muxes the matching nibble of a 32-bit display word, decodes it to segments, and inserts an anti-ghosting blank interval at the start of every slot.
- New display words arrive over a valid/ready handshake. They are double-buffered and applied only at frame boundaries, so the display never tears.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; must be >= 4.
- BLANK_CYC, 8: cycles at slot start with all anodes off; must satisfy 1 <= BLANK_CYC < REFRESH_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- load_valid  in  1  new display word offered
- load_ready  out  1  pending buffer empty, so the word is accepted
- load_data  in  32  hex digits; digit i = load_data[4i+3:4i]
- load_mask  in  8  per-digit enable; 1 = digit shown
- load_dp  in  8  per-digit decimal point; 1 = lit
- anode  out  8  active-low digit select, one-hot-low or 8'hFF
- seg  out  7  active-low cathodes; seg[0]=a ... seg[6]=g
- dp  out  1  active-low decimal point
- frame_done  out  1  one-cycle pulse at the end of the digit-7 slot

Interface: reset rst, asynchronous, active-high; clock clk.

Behaviour:
- Reset values:
  - anode=8'hFF, seg=7'h7F, dp=1, frame_done=0, load_ready=1.
  - cnt=0, idx=0, pending empty.
  - Active word: data=0, mask=8'h00 (display dark), dp=8'h00.
- Timing: cnt runs 0..REFRESH_DIV-1, then wraps to 0 and increments idx. idx runs 0..7, then wraps to 0.
- State per slot:
  - BLANK while cnt < BLANK_CYC.
  - SHOW while cnt >= BLANK_CYC.
  - BLANK -> SHOW at cnt==BLANK_CYC-1. SHOW -> BLANK at cnt==REFRESH_DIV-1.
- Outputs are registered and lag (cnt, idx) by exactly one clock.
- SHOW with active mask[idx]=1:
  - anode = ~(8'h01 << idx).
  - seg = decode(nibble idx).
  - dp = ~active_dp[idx].
- BLANK, or mask[idx]=0: anode=8'hFF, seg=7'h7F, dp=1.
- Decode covers 0-9 and A-F, with b and d in lower case.
- Frame boundary: cnt==REFRESH_DIV-1 && idx==7.
  - frame_done pulses on the registered cycle after the boundary.
  - If pending is full, pending moves to active and pending becomes empty. load_ready rises on the following cycle.
- Handshake:
  - A transfer occurs when load_valid && load_ready; pending captures data, mask and dp.
  - load_ready = !pending_full.
  - A word accepted in the boundary cycle itself waits for the next boundary. There is no bypass.
  - load_data/mask/dp need only be stable on the transfer cycle.
- Back-to-back loads: a second word stalls (load_ready=0) until the boundary. There is no overwrite or drop.
- Reset mid-frame: immediate dark display. Pending and active contents are discarded and counters return to 0.

Optional Feature:
- Macro: DISP_LZB_EN (leading-zero blanking).
- Defined: digits above the most significant nonzero nibble of the active data are treated as mask=0. Digit 0 always obeys mask only. If data==0, only digit 0 can show.
- Undefined: visibility is load_mask only.
- Port list is identical either way.

Decomposition:
- Package disp_pkg holds:
  - ANODE_OFF=8'hFF, SEG_OFF=7'h7F.
  - 16-entry segment constant table.
  - Slot state enum {BLANK, SHOW}.
  - DIGITS=8.
- Sub-module hex7seg_decode: combinational 4-bit -> 7-bit active-low. Instantiated once on the muxed nibble.

Test Plan (REFRESH_DIV=16, BLANK_CYC=2):
- Reset, no load -> anode=8'hFF and seg=7'h7F for 300 cycles. frame_done period is exactly 128 cycles.
- Load data=32'h76543210, mask=8'hFF, dp=8'h00 -> after the next frame_done, each digit i drives anode=~(1<<i) for 14 cycles, preceded by 2 cycles of 8'hFF. Digit 3 shows seg=7'h30 and dp=1.
- Load mask=8'hA5, dp=8'h01 -> digits 1, 3, 4 and 6 stay 8'hFF for the whole slot. Digit 0 shows dp=0.
- Two back-to-back loads (32'h11111111, then 32'h22222222):
  - load_ready drops after the first load and rises one cycle after the next boundary.
  - The second word is visible only after the following boundary.
- Assert rst at mid-slot, idx=5 -> next cycle anode=8'hFF, load_ready=1, previous word gone.
- With DISP_LZB_EN, data=32'h000000A3, mask=8'hFF -> only digits 0 and 1 are lit (seg 7'h30, 7'h08). Without the macro, digits 2-7 show "0" (7'h40).
